// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32I pipeline control path: controller state
// encoding, the control-vector layout and the default memory wait limit.
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } pipe_state_e;

    // Shared with the data-memory interface so both sides agree on the timeout.
    localparam int unsigned WAIT_MAX_DEFAULT = 15;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic bubble_ex;
        logic bubble_wb;
        logic pc_redirect;
    } pipe_ctl_t;

endpackage

// File: rtl/pipeline_ctrl_u_if.sv
// Hazard inputs from the pipeline and the stall/flush/bubble controls
// returned to it. The pipeline side is master, the controller is slave.
interface pipeline_ctrl_u_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             use_rs1;
    logic             use_rs2;
    logic             is_load_in_ex;
    logic             wr_reg_n_in_ex;
    logic [4:0]       rd_in_ex;
    logic             redirect_in_ex;
    logic             dmem_req;
    logic             dmem_ready;

    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_id;
    logic             bubble_ex;
    logic             bubble_wb;
    logic             pc_redirect;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs1, rs2, use_rs1, use_rs2, is_load_in_ex, wr_reg_n_in_ex,
               rd_in_ex, redirect_in_ex, dmem_req, dmem_ready,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
               bubble_wb, pc_redirect, mem_timeout, stall_cnt
    );

    modport slave (
        input  rs1, rs2, use_rs1, use_rs2, is_load_in_ex, wr_reg_n_in_ex,
               rd_in_ex, redirect_in_ex, dmem_req, dmem_ready,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
               bubble_wb, pc_redirect, mem_timeout, stall_cnt
    );

endinterface

// File: rtl/load_use_detect_u.sv
// Combinational load-use compare between the ID sources and the EX load
// destination; x0 never creates a hazard.
module load_use_detect_u (
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic       is_load_in_ex,
    input  logic       wr_reg_n_in_ex,
    input  logic [4:0] rd_in_ex,
    output logic       lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = use_rs1 && (rs1 == rd_in_ex);
    assign rs2_hit = use_rs2 && (rs2 == rd_in_ex);
    assign lu      = is_load_in_ex && !wr_reg_n_in_ex && (rd_in_ex != 5'd0)
                     && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl_u.sv
// Hazard and stall controller for the 5-stage RV32I core: per-cycle hold,
// flush and bubble decisions, PC redirect, stall counter and memory timeout.
module pipeline_ctrl_u
    import rv_pipe_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipeline_ctrl_u_if.slave  bus
);

    localparam int unsigned     WW       = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0]   WAIT_LIM = WW'(WAIT_MAX);

    pipe_state_e      state;
    logic [WW-1:0]    wait_cnt;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    logic             lu;
    logic             dmem_stall;
    logic             freeze;
    pipe_ctl_t        ctl;

    load_use_detect_u u_load_use (
        .rs1            (bus.rs1),
        .rs2            (bus.rs2),
        .use_rs1        (bus.use_rs1),
        .use_rs2        (bus.use_rs2),
        .is_load_in_ex  (bus.is_load_in_ex),
        .wr_reg_n_in_ex (bus.wr_reg_n_in_ex),
        .rd_in_ex       (bus.rd_in_ex),
        .lu             (lu)
    );

    assign dmem_stall = bus.dmem_req && !bus.dmem_ready;
    assign freeze     = dmem_stall || (state == ERR);

    // Controls are qualified by rst_n so reset silences them without a clock.
    always_comb begin
        // NOTE: default every field first so no path leaves a latch behind.
        ctl = '0;
        if (!rst_n) begin
            ctl = '0;
        end else if (freeze) begin
            ctl.stall_if  = 1'b1;
            ctl.stall_id  = 1'b1;
            ctl.stall_ex  = 1'b1;
            ctl.stall_mem = 1'b1;
            ctl.bubble_wb = 1'b1;
        end else if (bus.redirect_in_ex) begin
            ctl.pc_redirect = 1'b1;
            ctl.flush_id    = 1'b1;
            ctl.bubble_ex   = 1'b1;
        end else if (lu) begin
            ctl.stall_if  = 1'b1;
            ctl.stall_id  = 1'b1;
            ctl.bubble_ex = 1'b1;
        end
    end

    // The RUN->MEM_WAIT edge already counts the first stalled cycle, so the
    // ERR edge lands at the end of stalled cycle WAIT_MAX+1.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments only.
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (ctl.stall_if) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (dmem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WW'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LIM) begin
                        state       <= ERR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.stall_if    = ctl.stall_if;
    assign bus.stall_id    = ctl.stall_id;
    assign bus.stall_ex    = ctl.stall_ex;
    assign bus.stall_mem   = ctl.stall_mem;
    assign bus.flush_id    = ctl.flush_id;
    assign bus.bubble_ex   = ctl.bubble_ex;
    assign bus.bubble_wb   = ctl.bubble_wb;
    assign bus.pc_redirect = ctl.pc_redirect;
    assign bus.mem_timeout = mem_timeout;
    assign bus.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl_u.sv
// Self-checking bench for pipeline_ctrl_u: scenario tasks push expected
// control vectors to a scoreboard that is drained as the DUT settles.
module tb_pipeline_ctrl_u;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned CNT_W    = 4;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic bubble_ex;
        logic bubble_wb;
        logic pc_redirect;
        logic mem_timeout;
    } ctl_t;

    typedef struct {
        string            name;
        ctl_t             ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    localparam ctl_t NONE  = 9'b000000000;
    localparam ctl_t LU    = 9'b110001000;
    localparam ctl_t REDIR = 9'b000011010;
    localparam ctl_t FRZ   = 9'b111100100;
    localparam ctl_t ERRC  = 9'b111100101;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_ctrl_u_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl_u #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    exp_t             sb[$];

    function automatic ctl_t observed();
        return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
                bus.flush_id, bus.bubble_ex, bus.bubble_wb, bus.pc_redirect,
                bus.mem_timeout};
    endfunction

    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic ld,
                          input logic wrn, input logic [4:0] rd,
                          input logic redir, input logic req, input logic rdy);
        bus.rs1            = r1;
        bus.rs2            = r2;
        bus.use_rs1        = u1;
        bus.use_rs2        = u2;
        bus.is_load_in_ex  = ld;
        bus.wr_reg_n_in_ex = wrn;
        bus.rd_in_ex       = rd;
        bus.redirect_in_ex = redir;
        bus.dmem_req       = req;
        bus.dmem_ready     = rdy;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called just after a falling edge with inputs applied; checks, then
    // advances through the next rising edge to the following falling edge.
    task automatic cycle(input string name, input ctl_t exp);
        exp_t e;
        exp_t got;
        ctl_t o;
        e.name = name;
        e.ctl  = exp;
        e.cnt  = exp_cnt;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        o   = observed();
        n_tests++;
        if (o !== got.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b, expected %b", got.name, o, got.ctl);
        end
        n_tests++;
        if (bus.stall_cnt !== got.cnt) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d, expected %0d",
                     got.name, bus.stall_cnt, got.cnt);
        end
        if (rst_n && exp.stall_if) exp_cnt = exp_cnt + CNT_W'(1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.dmem_req = 1'b1;
        @(negedge clk);
        cycle("reset_0", NONE);
        cycle("reset_1", NONE);
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_load_use();
        set_in(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        cycle("lu_rs1", LU);
        set_in(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
        cycle("lu_release", NONE);
        set_in(5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        cycle("lu_rs2", LU);
        set_in(5'd5, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        cycle("lu_rs1_unused", NONE);
    endtask

    task automatic test_no_hazard();
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle("lu_x0", NONE);
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cycle("lu_no_write", NONE);
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        cycle("alu_dep", NONE);
    endtask

    task automatic test_redirect();
        set_in(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        cycle("redir_over_lu", REDIR);
        idle();
        cycle("redir_one_cycle", NONE);
    endtask

    task automatic test_mem_wait();
        set_in(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("mem_wait_frz", FRZ);
        bus.dmem_ready     = 1'b1;
        bus.is_load_in_ex  = 1'b0;
        cycle("mem_ready_held_redir", REDIR);
        idle();
        cycle("mem_back_run", NONE);
    endtask

    task automatic test_ready_same_cycle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        cycle("ready_same_cycle", NONE);
        bus.dmem_ready = 1'b0;
        cycle("single_wait", FRZ);
        bus.dmem_ready = 1'b1;
        cycle("single_wait_done", NONE);
        idle();
    endtask

    task automatic test_wait_boundary();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < int'(WAIT_MAX); i++) cycle("wait_max_frz", FRZ);
        bus.dmem_ready = 1'b1;
        cycle("wait_max_no_timeout", NONE);
        idle();
    endtask

    task automatic test_timeout();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < int'(WAIT_MAX) + 1; i++) cycle("timeout_frz", FRZ);
        for (int i = 0; i < 3; i++) cycle("err_frozen", ERRC);
        set_in(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        cycle("err_ignores_redir", ERRC);
        idle();
        cycle("err_sticky", ERRC);
    endtask

    task automatic test_reset_mid_wait();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n   = 1'b0;
        exp_cnt = '0;
        cycle("async_reset", NONE);
        cycle("reset_held", NONE);
        rst_n = 1'b1;
        cycle("post_reset_wait", FRZ);
        bus.dmem_ready = 1'b1;
        cycle("post_reset_ready", NONE);
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect();
        test_mem_wait();
        test_ready_same_cycle();
        test_wait_boundary();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl_u.md
# pipeline_ctrl_u

Pipeline hazard and stall controller for the 5-stage RV32I core. It does not produce forwarding selects. Each cycle it decides which stages hold, which pipeline registers receive a bubble, and when the front end is redirected. Inputs are a load-use hazard, a taken branch or jump resolved in EX, and a data-memory access that has not completed. It sits beside the forwarding unit, drives the enable and flush pins of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps a stall-cycle counter and a memory-timeout error flag.

## Interface
- WAIT_MAX, 15: maximum consecutive data-memory wait cycles before timeout (1..255).
- CNT_W, 32: stall counter width.

- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs1  in  5  ID source register 1
- rs2  in  5  ID source register 2
- use_rs1  in  1  ID instruction reads rs1
- use_rs2  in  1  ID instruction reads rs2
- is_load_in_ex  in  1  EX instruction is a load
- wr_reg_n_in_ex  in  1  EX instruction does not write rd (active-low write)
- rd_in_ex  in  5  EX destination
- redirect_in_ex  in  1  taken branch, JAL or JALR resolved in EX
- dmem_req  in  1  MEM instruction accesses data memory
- dmem_ready  in  1  data memory completes this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID
- stall_ex  out  1  hold ID/EX
- stall_mem  out  1  hold EX/MEM
- flush_id  out  1  load NOP into IF/ID
- bubble_ex  out  1  load NOP into ID/EX
- bubble_wb  out  1  load NOP into MEM/WB
- pc_redirect  out  1  PC takes EX target
- mem_timeout  out  1  sticky timeout error
- stall_cnt  out  CNT_W  cycles with any stall asserted

## Operation
- States are RUN, MEM_WAIT and ERR. Reset enters RUN. stall_cnt resets to 0, the wait counter to 0, and mem_timeout to 0.
- freeze = dmem_req & !dmem_ready, or state==ERR. While freeze is 1:
  - stall_if, stall_id, stall_ex and stall_mem are all 1.
  - bubble_wb is 1.
  - flush_id, bubble_ex and pc_redirect are forced to 0.
- Load-use hazard: lu = is_load_in_ex & !wr_reg_n_in_ex & rd_in_ex!=0 & ((use_rs1 & rs1==rd_in_ex) | (use_rs2 & rs2==rd_in_ex)).
- Priority 1, freeze: as above.
- Priority 2, redirect_in_ex: pc_redirect=1, flush_id=1, bubble_ex=1. This also covers lu, because the ID instruction is on the wrong path.
- Priority 3, lu: stall_if=1, stall_id=1, bubble_ex=1.
- Otherwise all outputs except mem_timeout and stall_cnt are 0.
- State transitions:
  - RUN to MEM_WAIT when freeze is caused by dmem.
  - MEM_WAIT to RUN in the cycle after dmem_ready=1.
  - MEM_WAIT to ERR when the wait counter equals WAIT_MAX and dmem_ready=0. mem_timeout is set on this edge.
  - ERR persists until rst_n.
- Wait counter: cleared in RUN, incremented each MEM_WAIT cycle, saturates at WAIT_MAX.
- stall_cnt increments by 1 on every cycle where stall_if=1 and wraps modulo 2^CNT_W. Bubbles alone do not count.

## Timing
- All stall, flush and bubble outputs are combinational from the current inputs and state, with zero latency. Pipeline registers sample them at the same clk edge.
- A load-use hazard costs exactly 1 stall cycle. In the next cycle the load is in MEM, lu=0, and forwarding from MEM supplies the data.
- Redirect: flush_id and bubble_ex last 1 cycle. The target fetch starts on the next cycle.
- A redirect coincident with a dmem wait is held, because EX is frozen. It applies in the first cycle with freeze=0.
- dmem_ready may arrive in the request cycle. The cost is then 0 stall cycles and the state stays RUN.
- The ERR transition happens after WAIT_MAX+1 stalled cycles with no ready.
- Asserting rst_n low mid-wait returns to RUN and clears all outputs asynchronously.

## Structure
- rv_pipe_pkg holds the state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2) and a default WAIT_MAX constant shared with the memory interface.
- One sub-module, load_use_detect_u: the combinational lu compare, reusable by the forwarding unit's test bench.

## Test plan
- Load x5 then add x6,x5,x1 in ID: 1 cycle with stall_if=stall_id=bubble_ex=1, then free, stall_cnt=1.
- Load x0 then use x0, or wr_reg_n_in_ex=1: no stall.
- redirect_in_ex=1 with lu=1 in the same cycle: pc_redirect=flush_id=bubble_ex=1, stall_if=0, stall_cnt unchanged.
- dmem_req=1, dmem_ready low for 3 cycles then high: freeze for 3 cycles, state MEM_WAIT, back to RUN after ready, stall_cnt=3.
- WAIT_MAX=4 with ready never asserted: mem_timeout=1 after 5 stall cycles, freeze is permanent. rst_n pulse clears everything.
- Preload stall_cnt to 2^CNT_W-1 with a stall: wraps to 0.
